// File: rtl/uart_tx_pkg.sv
// Shared definitions for the 8N1 UART transmitter: FSM encoding, frame shape
// and the default clocking that the divider control block also derives from.
package uart_tx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS        = 8;
  localparam int STOP_BITS        = 1;
  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD     = 9600;
endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO. A push into a full FIFO is
// still taken when a pop happens in the same cycle.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] dout,
  output logic                 empty,
  output logic                 full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 wr_en;
  logic                 rd_en;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: buffers byte strobes in a small FIFO and serialises
// them LSB first, chaining frames back-to-back with no idle gap.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overflow
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_t            state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 baud_tc;

  assign baud_tc = (baud_cnt == LAST);
  // A byte is loaded from IDLE, or straight out of the last stop-bit cycle.
  assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_tc));
  assign busy = (state != IDLE) || !fifo_empty;

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_ready),
    .din   (tx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) overflow <= 1'b0;
    else if (tx_ready && fifo_full && !pop) overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= fifo_dout;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              tx    <= 1'b1;
              done  <= (PRE_LAST == '0);
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + BW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= fifo_dout;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
            // done is registered, so raise it one cycle ahead of the final stop cycle.
            done     <= (baud_cnt == PRE_LAST);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed/randomised bench for uart_tx: each frame is rebuilt from the byte
// it should carry and compared bit period by bit period.
module tb_uart_tx;
  localparam int CF    = 1_000_000;
  localparam int BD    = 100_000;
  localparam int CPB   = CF / BD;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx;
  logic       busy;
  logic       done;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  byte unsigned exp_q[$];
  byte unsigned drv_q[$];
  byte unsigned late_byte;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(CF), .BAUD(BD), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic idle_check(input int n);
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle_bad_cycles", bad, 0);
  endtask

  // Each expected frame is {stop=1, data LSB first, start=0}, CPB cycles per bit.
  task automatic check_frames(input int n);
    for (int f = 0; f < n; f++) begin
      byte unsigned b;
      logic [9:0] expw;
      logic [9:0] obs;
      int glitch = 0;
      int dcnt = 0;
      int dpos = -1;
      int nbusy = 0;
      b = exp_q.pop_front();
      expw = {1'b1, b, 1'b0};
      obs = 'x;
      for (int c = 0; c < CPB * 10; c++) begin
        @(negedge clk);
        if (c % CPB == 0) obs[c / CPB] = tx;
        else if (tx !== obs[c / CPB]) glitch++;
        if (done === 1'b1) begin dcnt++; dpos = c; end
        if (busy !== 1'b1) nbusy++;
      end
      chk($sformatf("frame%0d_bits", f), obs, expw);
      chk($sformatf("frame%0d_glitch", f), glitch, 0);
      chk($sformatf("frame%0d_done_cnt", f), dcnt, 1);
      chk($sformatf("frame%0d_done_pos", f), dpos, CPB * 10 - 1);
      chk($sformatf("frame%0d_busy_low", f), nbusy, 0);
    end
  endtask

  task automatic drive(input int late_at);
    while (drv_q.size() > 0) begin
      tx_ready = 1'b1;
      tx_data  = drv_q.pop_front();
      @(negedge clk);
    end
    tx_ready = 1'b0;
    tx_data  = $urandom;
    if (late_at > 0) begin
      repeat (late_at) @(negedge clk);
      tx_ready = 1'b1;
      tx_data  = late_byte;
      @(negedge clk);
      tx_ready = 1'b0;
    end
  endtask

  // Must be entered on a falling edge; the first frame cycle is two falling edges later.
  task automatic run(input int nframes, input int late_at);
    fork
      drive(late_at);
      begin
        @(negedge clk);
        check_frames(nframes);
      end
    join
    @(negedge clk);
    chk("after_busy", busy, 1'b0);
    chk("after_tx", tx, 1'b1);
  endtask

  task automatic load_burst(input int k);
    for (int i = 0; i < k; i++) begin
      byte unsigned b;
      b = byte'($urandom);
      drv_q.push_back(b);
      if (i <= DEPTH) exp_q.push_back(b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst = 1'b1;
    idle_check(50);
    chk("idle_overflow", overflow, 1'b0);

    // Single byte
    drv_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    run(1, 0);

    // Four consecutive strobes, as the control block emits them
    drv_q = '{8'h34, 8'h12, 8'h02, 8'h00};
    exp_q = '{8'h34, 8'h12, 8'h02, 8'h00};
    run(4, 0);
    chk("burst4_overflow", overflow, 1'b0);

    // Random single and burst traffic
    load_burst(1);
    run(1, 0);
    load_burst(3);
    run(3, 0);
    chk("burst3_overflow", overflow, 1'b0);

    // Six strobes: one in flight plus DEPTH buffered, the sixth is dropped
    load_burst(6);
    run(DEPTH + 1, 0);
    chk("burst6_overflow", overflow, 1'b1);
    idle_check(20);
    chk("overflow_sticky", overflow, 1'b1);

    // Push into a full FIFO on the same edge as the pop out of STOP
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst2_overflow", overflow, 1'b0);
    load_burst(DEPTH + 1);
    late_byte = byte'($urandom);
    exp_q.push_back(late_byte);
    run(DEPTH + 2, CPB * 10 - DEPTH);
    chk("full_pop_overflow", overflow, 1'b0);

    // Reset in the middle of a frame
    drv_q.push_back(byte'($urandom));
    fork
      drive(0);
      repeat (36) @(negedge clk);
    join
    chk("midframe_busy_before", busy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    rst = 1'b1;
    idle_check(15);
    drv_q.push_back(8'h5A);
    exp_q.push_back(8'h5A);
    run(1, 0);
    chk("final_overflow", overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
